// File: rtl/rsa_pkg.sv
`default_nettype none
// rsa_pkg -- shared probe state encoding and default widths (rev 1.0).
package rsa_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_latency_counter.sv
`default_nettype none
// rsa_latency_counter -- clear/enable cycle counter with a terminal flag at TIMEOUT (rev 1.0).
module rsa_latency_counter
  import rsa_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == CNT_W'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/rsa_timing_probe.sv
`default_nettype none
// rsa_timing_probe -- issues a ciphertext sequence to an RSA decrypt core and streams
// per-operation latency records (c, m, cycles, timeout) (rev 1.0).
module rsa_timing_probe
  import rsa_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = 4096,
  parameter int NUM_SAMPLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [2*WIDTH-1:0] c_base,
  input  logic [2*WIDTH-1:0] c_step,
  output logic               dut_start,
  output logic [2*WIDTH-1:0] dut_c,
  input  logic               dut_finish,
  input  logic [2*WIDTH-1:0] dut_m,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [2*WIDTH-1:0] sample_c,
  output logic [2*WIDTH-1:0] sample_m,
  output logic [CNT_W-1:0]   sample_cycles,
  output logic               sample_timeout,
  output logic               busy,
  output logic               done
);

  localparam int DW    = 2 * WIDTH;
  localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    cur_c_q, cur_c_d;
  logic [DW-1:0]    step_q, step_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dut_start_q, dut_start_d;
  logic [DW-1:0]    dut_c_q, dut_c_d;
  logic             s_valid_q, s_valid_d;
  logic [DW-1:0]    s_c_q, s_c_d;
  logic [DW-1:0]    s_m_q, s_m_d;
  logic [CNT_W-1:0] s_cyc_q, s_cyc_d;
  logic             s_to_q, s_to_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_run;
  logic [CNT_W-1:0] cnt;
  logic             cnt_at_limit;

  // Counter runs through LAUNCH so it already reads 1 in the first WAIT cycle.
  assign cnt_run = (state_q == LAUNCH) || (state_q == WAIT);

  rsa_latency_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!cnt_run),
    .en       (cnt_run),
    .cnt      (cnt),
    .at_limit (cnt_at_limit)
  );

  always_comb begin
    state_d = state_q;
    cur_c_d = cur_c_q;
    step_d  = step_q;
    idx_d   = idx_q;
    s_c_d   = s_c_q;
    s_m_d   = s_m_q;
    s_cyc_d = s_cyc_q;
    s_to_d  = s_to_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          cur_c_d = c_base;
          step_d  = c_step;
          idx_d   = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // A finish in the terminal cycle still counts as a completed operation.
        if (dut_finish) begin
          s_c_d   = cur_c_q;
          s_m_d   = dut_m;
          s_cyc_d = cnt;
          s_to_d  = 1'b0;
          state_d = REPORT;
        end else if (cnt_at_limit) begin
          s_c_d   = cur_c_q;
          s_m_d   = '0;
          s_cyc_d = cnt;
          s_to_d  = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (sample_ready) begin
          if (s_to_q || (idx_q == LAST_IDX)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cur_c_d = cur_c_q + step_q;
            state_d = LAUNCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    dut_start_d = (state_d == LAUNCH);
    dut_c_d     = (state_d == LAUNCH) ? cur_c_d : dut_c_q;
    s_valid_d   = (state_d == REPORT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_c_q     <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      dut_start_q <= 1'b0;
      dut_c_q     <= '0;
      s_valid_q   <= 1'b0;
      s_c_q       <= '0;
      s_m_q       <= '0;
      s_cyc_q     <= '0;
      s_to_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_c_q     <= cur_c_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      dut_start_q <= dut_start_d;
      dut_c_q     <= dut_c_d;
      s_valid_q   <= s_valid_d;
      s_c_q       <= s_c_d;
      s_m_q       <= s_m_d;
      s_cyc_q     <= s_cyc_d;
      s_to_q      <= s_to_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dut_start      = dut_start_q;
  assign dut_c          = dut_c_q;
  assign sample_valid   = s_valid_q;
  assign sample_c       = s_c_q;
  assign sample_m       = s_m_q;
  assign sample_cycles  = s_cyc_q;
  assign sample_timeout = s_to_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_timing_probe.sv
`default_nettype none
// tb_rsa_timing_probe -- scoreboard bench with a fixed-latency core model (m = c ^ 1).
module tb_rsa_timing_probe;

  localparam int W  = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TO = 20;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] c_base = '0;
  logic [DW-1:0] c_step = '0;
  logic          dut_start;
  logic [DW-1:0] dut_c;
  logic          dut_finish = 1'b0;
  logic [DW-1:0] dut_m = '0;
  logic          sample_valid;
  logic          sample_ready = 1'b1;
  logic [DW-1:0] sample_c;
  logic [DW-1:0] sample_m;
  logic [CW-1:0] sample_cycles;
  logic          sample_timeout;
  logic          busy;
  logic          done;

  rsa_timing_probe #(
    .WIDTH       (W),
    .CNT_W       (CW),
    .TIMEOUT     (TO),
    .NUM_SAMPLES (NS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .c_base         (c_base),
    .c_step         (c_step),
    .dut_start      (dut_start),
    .dut_c          (dut_c),
    .dut_finish     (dut_finish),
    .dut_m          (dut_m),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_c       (sample_c),
    .sample_m       (sample_m),
    .sample_cycles  (sample_cycles),
    .sample_timeout (sample_timeout),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] c;
    logic [DW-1:0] m;
    logic [CW-1:0] cyc;
    logic          to;
  } rec_t;

  rec_t          exp_q[$];
  logic [DW-1:0] start_q[$];

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_done = 0;
  int epoch = 0;
  int lat = 5;
  bit early = 1'b0;
  int hold_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the ciphertext sequence, stopping after the first timeout.
  task automatic expect_run(input logic [DW-1:0] base, input logic [DW-1:0] step, input int l);
    logic [DW-1:0] c;
    rec_t r;
    for (int i = 0; i < NS; i++) begin
      c = base + DW'(i) * step;
      start_q.push_back(c);
      if (l == 0 || l > TO) begin
        r = '{c: c, m: '0, cyc: CW'(TO), to: 1'b1};
        exp_q.push_back(r);
        break;
      end
      r = '{c: c, m: c ^ 16'h0001, cyc: CW'(l), to: 1'b0};
      exp_q.push_back(r);
    end
  endtask

  // Core model: finish l cycles after start; l == 0 means hung.
  initial begin : core_model
    logic [DW-1:0] c;
    int            my_epoch;
    int            l;
    int            rem;
    forever begin
      @(negedge clk);
      if (rst_n && dut_start) begin
        c        = dut_c;
        my_epoch = epoch;
        l        = lat;
        rem      = l;
        if (early) begin
          dut_finish = 1'b1;
          dut_m      = 16'hDEAD;
          @(negedge clk);
          dut_finish = 1'b0;
          rem        = l - 1;
        end
        if (l > 0) begin
          if (rem > 0) repeat (rem) @(negedge clk);
          if (epoch == my_epoch) begin
            dut_finish = 1'b1;
            dut_m      = c ^ 16'h0001;
            @(negedge clk);
            dut_finish = 1'b0;
          end
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0 && sample_valid) begin
        sample_ready = 1'b0;
        hold_cnt--;
      end else begin
        sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin : monitor
    bit            holding;
    logic [48:0]   snap;
    logic [DW-1:0] sc;
    rec_t          r;
    holding = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
      end else begin
        if (dut_start) begin
          n_start++;
          check("start_while_valid", sample_valid, 1'b0);
          if (start_q.size() == 0) begin
            check("unexpected_start", 1'b1, 1'b0);
          end else begin
            sc = start_q.pop_front();
            check("dut_c", dut_c, sc);
          end
        end
        if (done) begin
          n_done++;
          check("busy_in_done", busy, 1'b1);
        end
        if (sample_valid) begin
          if (holding)
            check("hold_stable", {sample_c, sample_m, sample_cycles, sample_timeout}, snap);
          if (sample_ready) begin
            holding = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_record", 1'b1, 1'b0);
            end else begin
              r = exp_q.pop_front();
              check("record", {sample_c, sample_m, sample_cycles, sample_timeout}, r);
            end
          end else if (!holding) begin
            holding = 1'b1;
            snap    = {sample_c, sample_m, sample_cycles, sample_timeout};
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_a"}, {dut_start, dut_c, sample_valid, sample_c, busy, done}, '0);
    check({name, "_b"}, {sample_m, sample_cycles, sample_timeout}, '0);
  endtask

  task automatic run_once(input logic [DW-1:0] base, input logic [DW-1:0] step, input int l,
                          input bit e, input int hold, input bit junk);
    int exp_starts;
    lat      = l;
    early    = e;
    hold_cnt = hold;
    expect_run(base, step, l);
    exp_starts = start_q.size();
    n_start  = 0;
    n_done   = 0;
    @(posedge clk); #1;
    run    = 1'b1;
    c_base = base;
    c_step = step;
    @(posedge clk); #1;
    run    = 1'b0;
    c_base = DW'($urandom);
    c_step = DW'($urandom);
    check("run_to_start", dut_start, 1'b1);
    if (junk) begin
      repeat (3) @(posedge clk);
      #1;
      run    = 1'b1;
      c_base = 16'h1234;
      @(posedge clk); #1;
      run    = 1'b0;
    end
    for (int i = 0; i < 3000 && n_done == 0; i++) @(posedge clk);
    check("done_seen", n_done > 0, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("done_count", n_done, 1);
    check("start_count", n_start, exp_starts);
    check("records_left", exp_q.size(), 0);
    if (n_done == 0) begin
      rst_n = 1'b0;
      epoch++;
      exp_q.delete();
      start_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;

    run_once(16'd3, 16'd2, 5, 1'b0, 0, 1'b0);
    run_once(16'd100, 16'd7, 1, 1'b1, 0, 1'b0);
    run_once(16'd40, 16'd1, 0, 1'b0, 0, 1'b0);
    run_once(16'd9, 16'd4, 3, 1'b0, 7, 1'b0);
    run_once(16'hFFFE, 16'd3, 4, 1'b0, 0, 1'b1);
    run_once(16'd500, 16'd1, TO, 1'b0, 0, 1'b0);
    run_once(16'd77, 16'd5, TO + 1, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a WAIT.
    lat   = 8;
    early = 1'b0;
    expect_run(16'd10, 16'd1, 8);
    @(posedge clk); #1;
    run    = 1'b1;
    c_base = 16'd10;
    c_step = 16'd1;
    @(posedge clk); #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    epoch++;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    start_q.delete();
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_once(16'd3, 16'd2, 5, 1'b0, 0, 1'b0);

    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_once(DW'($urandom), DW'($urandom), $urandom_range(1, TO + 3), 1'b0, 0, 1'b0);
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
